regfile_2r1w: RTL and testbench

- Parametrised successor to the team's single load/clear register: DEPTH registers of WIDTH bits each.
- One synchronous write port, two combinational read ports, and a per-entry valid bit.
- Adds a synchronous bulk clear and an optional hardwired-zero entry 0.
- Sits between datapath ALU result bus and operand fetch in the lab CPU datapath.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_2r1w_entry.sv | 24 ++
 rtl/regfile_2r1w.sv | 66 ++++++
 tb/tb_regfile_2r1w.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, read-result type and address range helper for regfile_2r1w.
package regfile_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
    logic                     valid;
  } rd_res_t;
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction
endpackage

// File: rtl/regfile_2r1w_entry.sv
// reg_entry: one WIDTH-bit register with valid bit; async clear, then sync clear, then load.
module reg_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic             sclr,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             valid
);
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      out   <= '0;
      valid <= 1'b0;
    end else if (sclr) begin
      out   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      out   <= in;
      valid <= 1'b1;
    end
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file, one sync write, two comb reads, per-entry valid.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              clr_all,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b
);
  localparam int N = 2 ** ADDR_W;
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
  } port_t;
  logic [WIDTH-1:0] q [N];
  logic             v [N];
  logic             wr_ok;
  port_t            pa, pb;
  assign wr_ok = clear_n && we && !clr_all && addr_in_range(32'(waddr), DEPTH)
               && !(ZERO_REG != 0 && waddr == '0);
  // Unused address slots are tied to 0/invalid so the read muxes never see X.
  for (genvar i = 0; i < N; i++) begin : g_ent
    if (i >= DEPTH) begin : g_oor
      assign q[i] = '0;
      assign v[i] = 1'b0;
    end else if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign q[i] = '0;
      assign v[i] = 1'b1;
    end else begin : g_reg
      reg_entry #(.WIDTH(WIDTH)) u_entry (
        .clk   (clk),
        .clear_n(clear_n),
        .load  (wr_ok && waddr == ADDR_W'(i)),
        .sclr  (clr_all),
        .in    (wdata),
        .out   (q[i]),
        .valid (v[i])
      );
    end
  end
`ifdef REGFILE_BYPASS_EN
  assign pa = (wr_ok && raddr_a == waddr) ? port_t'{wdata, 1'b1} : port_t'{q[raddr_a], v[raddr_a]};
  assign pb = (wr_ok && raddr_b == waddr) ? port_t'{wdata, 1'b1} : port_t'{q[raddr_b], v[raddr_b]};
`else
  assign pa = port_t'{q[raddr_a], v[raddr_a]};
  assign pb = port_t'{q[raddr_b], v[raddr_b]};
`endif
  assign rdata_a  = pa.data;
  assign rvalid_a = pa.valid;
  assign rdata_b  = pb.data;
  assign rvalid_b = pb.valid;
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: random + directed checks of two regfile_2r1w configs against an array model.
module tb_regfile_2r1w;
  logic       clk = 0, clear_n = 0, we = 0, clr_all = 0;
  logic [2:0] waddr = 0, raddr_a = 0, raddr_b = 0;
  logic [7:0] wdata = 0;
  logic [7:0] rda0, rdb0, rda1, rdb1;
  logic       rva0, rvb0, rva1, rvb1;
  int         errors = 0, checks = 0;
  logic [7:0] mem [2][8];
  logic       val [2][8];

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) u0 (
    .clk(clk), .clear_n(clear_n), .we(we), .waddr(waddr), .wdata(wdata), .clr_all(clr_all),
    .raddr_a(raddr_a), .rdata_a(rda0), .rvalid_a(rva0),
    .raddr_b(raddr_b), .rdata_b(rdb0), .rvalid_b(rvb0));
  regfile_2r1w #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1)) u1 (
    .clk(clk), .clear_n(clear_n), .we(we), .waddr(waddr), .wdata(wdata), .clr_all(clr_all),
    .raddr_a(raddr_a), .rdata_a(rda1), .rvalid_a(rva1),
    .raddr_b(raddr_b), .rdata_b(rdb1), .rvalid_b(rvb1));

  function automatic int depth_of(int k);
    return k == 1 ? 6 : 8;
  endfunction

  function automatic logic writable(int k, int a);
    return a < depth_of(k) && !(k == 1 && a == 0);
  endfunction

  // Expected {valid, data} for config k reading address a under current inputs.
  function automatic logic [8:0] expect_rd(int k, int a);
    if (k == 1 && a == 0) return 9'h100;
    if (a >= depth_of(k) || !clear_n) return 9'h000;
`ifdef REGFILE_BYPASS_EN
    if (we && !clr_all && a == int'(waddr) && writable(k, a)) return {1'b1, wdata};
`endif
    return {val[k][a], mem[k][a]};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    check($sformatf("%s u0 A@%0d", tag, raddr_a), {rva0, rda0}, expect_rd(0, int'(raddr_a)));
    check($sformatf("%s u0 B@%0d", tag, raddr_b), {rvb0, rdb0}, expect_rd(0, int'(raddr_b)));
    check($sformatf("%s u1 A@%0d", tag, raddr_a), {rva1, rda1}, expect_rd(1, int'(raddr_a)));
    check($sformatf("%s u1 B@%0d", tag, raddr_b), {rvb1, rdb1}, expect_rd(1, int'(raddr_b)));
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 8; a++) begin
        mem[k][a] = '0;
        val[k][a] = 1'b0;
      end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!clear_n || clr_all) model_clear();
    else if (we)
      for (int k = 0; k < 2; k++)
        if (writable(k, int'(waddr))) begin
          mem[k][waddr] = wdata;
          val[k][waddr] = 1'b1;
        end
    @(negedge clk);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 8; a++) begin
      raddr_a = 3'(a);
      raddr_b = 3'(7 - a);
      #1 check_reads(tag);
    end
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d);
    we = 1; waddr = a; wdata = d;
    tick();
    we = 0;
  endtask

  initial begin
    model_clear();
    #1 sweep("reset");
    @(negedge clk);
    clear_n = 1;
    tick();
    // first write and next-cycle visibility
    we = 1; waddr = 3; wdata = 8'hA5; raddr_a = 3; raddr_b = 4;
    #1 check_reads("wr_cycle");
    tick();
    we = 0;
    #1 check_reads("wr3");
    check("wr3 const A", {rva0, rda0}, 9'h1A5);
    check("wr3 const B", {rvb0, rdb0}, 9'h000);
    // clear beats a same-edge write
    write(3'd1, 8'h11);
    we = 1; waddr = 2; wdata = 8'h3C; clr_all = 1;
    tick();
    we = 0; clr_all = 0;
    sweep("clr");
    raddr_a = 2;
    #1 check("clr const e2", {rva0, rda0}, 9'h000);
    // hardwired zero entry in u1
    write(3'd0, 8'hFF);
    raddr_a = 0;
    #1 check_reads("zr");
    check("zr u1 const", {rva1, rda1}, 9'h100);
    check("zr u0 const", {rva0, rda0}, 9'h1FF);
    clr_all = 1;
    tick();
    clr_all = 0;
    #1 check("zr u1 after clr", {rva1, rda1}, 9'h100);
    // async reset mid-cycle, write blocked during reset, honoured at first edge after release
    write(3'd5, 8'h55);
    #2 clear_n = 0;
    model_clear();
    raddr_a = 5; raddr_b = 0;
    #1 check_reads("async");
    check("async const", {rva0, rda0}, 9'h000);
    check("async zr const", {rvb1, rdb1}, 9'h100);
    we = 1; waddr = 5; wdata = 8'h77;
    tick();
    clear_n = 1; waddr = 6; wdata = 8'h66;
    tick();
    we = 0; raddr_a = 5; raddr_b = 6;
    #1 check_reads("release");
    check("release blocked", {rva0, rda0}, 9'h000);
    check("release honoured", {rvb0, rdb0}, 9'h166);
    // out-of-range write on DEPTH=6 instance
    write(3'd7, 8'hE7);
    sweep("oor");
    raddr_b = 7;
    #1 check("oor u1 const", {rvb1, rdb1}, 9'h000);
    check("oor u0 const", {rvb0, rdb0}, 9'h1E7);
    // forwarding
    write(3'd1, 8'h22);
    we = 1; waddr = 1; wdata = 8'h5A; raddr_a = 1; raddr_b = 1;
    #1 check_reads("byp");
`ifdef REGFILE_BYPASS_EN
    check("byp const", {rva0, rda0}, 9'h15A);
`else
    check("byp const", {rva0, rda0}, 9'h122);
`endif
    tick();
    we = 0;
    #1 check("byp next", {rvb1, rdb1}, 9'h15A);
    // random traffic
    repeat (400) begin
      logic nc;
      nc = $urandom_range(0, 59) != 0;
      if (!nc) model_clear();
      clear_n = nc;
      we = $urandom_range(0, 2) != 0;
      clr_all = $urandom_range(0, 15) == 0;
      waddr = 3'($urandom);
      wdata = 8'($urandom);
      raddr_a = $urandom_range(0, 1) != 0 ? waddr : 3'($urandom);
      raddr_b = 3'($urandom);
      #1 check_reads("rnd");
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
